// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: requester, bus and stall signals of the memory bus arbiter
interface mem_bus_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;
  logic        stall_if;
  logic        stall_mem;
  modport master (
    input  if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata, bus_rdata, bus_ack,
    output if_rdata, if_ack, mem_rdata, mem_ack, bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
           bus_err, stall_if, stall_mem
  );
  modport slave (
    output if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata, bus_rdata, bus_ack,
    input  if_rdata, if_ack, mem_rdata, mem_ack, bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
           bus_err, stall_if, stall_mem
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: MEM-priority arbiter for IF/MEM with fairness, wait states and bus watchdog
module mem_bus_arbiter #(
  parameter int unsigned MAX_MEM_RUN = 4,
  parameter int unsigned TIMEOUT     = 16
) (
  input logic             clk,
  input logic             rst,
  mem_bus_arbiter_if.master m
);
  localparam int unsigned RW = $clog2(MAX_MEM_RUN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [RW-1:0] RUN_MAX = RW'(MAX_MEM_RUN);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, DONE} state_t;
  state_t state, nxt;
  logic [RW-1:0] run_cnt;
  logic [TW-1:0] to_cnt;
  logic err, gnt_mem, grant_mem, busy, fin;
  always_comb begin
    grant_mem = m.mem_req && !(m.if_req && run_cnt == RUN_MAX);
    busy = state == BUSY_IF || state == BUSY_MEM;
    fin = busy && (m.bus_ack || to_cnt == TO_LAST);
    nxt = state;
    case (state)
      IDLE:              nxt = grant_mem ? BUSY_MEM : m.if_req ? BUSY_IF : IDLE;
      BUSY_IF, BUSY_MEM: nxt = fin ? DONE : state;
      default:           nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  // DONE gives the requester one cycle to see ack and drop req before re-arbitration
  assign m.if_ack    = state == DONE && !gnt_mem;
  assign m.mem_ack   = state == DONE && gnt_mem;
  assign m.bus_err   = state == DONE && err;
  assign m.stall_if  = !rst && m.if_req && !(state == DONE && !gnt_mem);
  assign m.stall_mem = !rst && m.mem_req && !(state == DONE && gnt_mem);
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt     <= '0;
      to_cnt      <= '0;
      err         <= 1'b0;
      gnt_mem     <= 1'b0;
      m.bus_req   <= 1'b0;
      m.bus_we    <= 1'b0;
      m.bus_sel   <= '0;
      m.bus_addr  <= '0;
      m.bus_wdata <= '0;
      m.if_rdata  <= '0;
      m.mem_rdata <= '0;
    end else if (state == IDLE) begin
      to_cnt <= '0;
      if (grant_mem || m.if_req) begin
        gnt_mem     <= grant_mem;
        m.bus_req   <= 1'b1;
        m.bus_we    <= grant_mem && m.mem_we;
        m.bus_sel   <= grant_mem ? m.mem_sel : 4'hF;
        m.bus_addr  <= grant_mem ? m.mem_addr : m.if_addr;
        m.bus_wdata <= grant_mem ? m.mem_wdata : '0;
        run_cnt     <= (grant_mem && m.if_req) ? (run_cnt == RUN_MAX ? run_cnt : run_cnt + 1'b1) : '0;
      end
    end else if (busy) begin
      if (fin) begin
        m.bus_req <= 1'b0;
        err       <= !m.bus_ack;
        if (gnt_mem) m.mem_rdata <= m.bus_ack ? m.bus_rdata : '0;
        else m.if_rdata <= m.bus_ack ? m.bus_rdata : '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end else begin
      err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenario bench for mem_bus_arbiter with a wait-state bus responder
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mem_bus_arbiter_if ifc();
  mem_bus_arbiter #(.MAX_MEM_RUN(4), .TIMEOUT(16)) dut (.clk(clk), .rst(rst), .m(ifc.master));
  int checks = 0;
  int errors = 0;
  int wait_states = 0;
  int ws_cnt = 0;
  bit hang = 1'b0;
  bit force_ack = 1'b0;
  logic [31:0] rkey = 32'h0;
  // responder: read data is address xor rkey, ack after wait_states busy cycles
  always @(negedge clk) begin
    ifc.bus_ack = force_ack || (ifc.bus_req === 1'b1 && !hang && ws_cnt == wait_states);
    ifc.bus_rdata = ifc.bus_addr ^ rkey;
    ws_cnt = (ifc.bus_req === 1'b1) ? ws_cnt + 1 : 0;
  end
  task automatic test_reset();
    rst = 1'b1;
    ifc.if_req = 1'b1; ifc.if_addr = 32'h0;
    ifc.mem_req = 1'b1; ifc.mem_we = 1'b1; ifc.mem_sel = 4'hF;
    ifc.mem_addr = 32'h0; ifc.mem_wdata = 32'h0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ifc.bus_req, ifc.bus_we, ifc.bus_sel, ifc.bus_addr, ifc.bus_wdata, ifc.if_rdata, ifc.mem_rdata,
         ifc.if_ack, ifc.mem_ack, ifc.bus_err} !== 137'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {ifc.bus_req, ifc.bus_we, ifc.bus_sel, ifc.bus_addr,
               ifc.bus_wdata, ifc.if_rdata, ifc.mem_rdata, ifc.if_ack, ifc.mem_ack, ifc.bus_err});
    end
    checks++;
    if ({ifc.stall_if, ifc.stall_mem} !== 2'b00) begin
      errors++;
      $display("FAIL reset_stall: got %b expected 00", {ifc.stall_if, ifc.stall_mem});
    end
    ifc.if_req = 1'b0; ifc.mem_req = 1'b0; ifc.mem_we = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ifc.bus_req, ifc.if_ack, ifc.mem_ack, ifc.stall_if, ifc.stall_mem} !== 5'b0) begin
      errors++;
      $display("FAIL reset_idle: got %b expected 00000",
               {ifc.bus_req, ifc.if_ack, ifc.mem_ack, ifc.stall_if, ifc.stall_mem});
    end
  endtask
  task automatic test_if_fetch();
    rkey = 32'h24010105; wait_states = 0;
    ifc.if_addr = 32'h100; ifc.if_req = 1'b1;
    #1;
    checks++;
    if (ifc.stall_if !== 1'b1) begin errors++; $display("FAIL fetch_stall_pre: got %b expected 1", ifc.stall_if); end
    @(negedge clk);
    checks++;
    if ({ifc.bus_req, ifc.bus_we, ifc.bus_sel, ifc.bus_addr} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
      errors++;
      $display("FAIL fetch_bus: got %h expected %h", {ifc.bus_req, ifc.bus_we, ifc.bus_sel, ifc.bus_addr},
               {1'b1, 1'b0, 4'hF, 32'h100});
    end
    checks++;
    if ({ifc.if_ack, ifc.stall_if} !== 2'b01) begin errors++; $display("FAIL fetch_wait: got %b expected 01", {ifc.if_ack, ifc.stall_if}); end
    @(negedge clk);
    checks++;
    if ({ifc.if_ack, ifc.bus_err, ifc.stall_if, ifc.bus_req} !== 4'b1000) begin
      errors++;
      $display("FAIL fetch_ack: got %b expected 1000", {ifc.if_ack, ifc.bus_err, ifc.stall_if, ifc.bus_req});
    end
    checks++;
    if (ifc.if_rdata !== 32'h24010005) begin errors++; $display("FAIL fetch_rdata: got %h expected 24010005", ifc.if_rdata); end
    ifc.if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (ifc.if_ack !== 1'b0) begin errors++; $display("FAIL fetch_pulse: got %b expected 0", ifc.if_ack); end
  endtask
  task automatic test_store();
    rkey = 32'h0; wait_states = 3;
    ifc.mem_we = 1'b1; ifc.mem_sel = 4'h3; ifc.mem_addr = 32'h2000; ifc.mem_wdata = 32'hDEADBEEF;
    ifc.mem_req = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({ifc.bus_req, ifc.bus_we, ifc.bus_sel, ifc.bus_addr, ifc.bus_wdata, ifc.mem_ack} !==
          {1'b1, 1'b1, 4'h3, 32'h2000, 32'hDEADBEEF, 1'b0}) begin
        errors++;
        $display("FAIL store_busy%0d: got %h expected %h", i,
                 {ifc.bus_req, ifc.bus_we, ifc.bus_sel, ifc.bus_addr, ifc.bus_wdata, ifc.mem_ack},
                 {1'b1, 1'b1, 4'h3, 32'h2000, 32'hDEADBEEF, 1'b0});
      end
      if (i == 1) ifc.mem_addr = 32'h3000;
      @(negedge clk);
    end
    checks++;
    if ({ifc.mem_ack, ifc.bus_err, ifc.bus_req, ifc.stall_mem} !== 4'b1000) begin
      errors++;
      $display("FAIL store_ack: got %b expected 1000", {ifc.mem_ack, ifc.bus_err, ifc.bus_req, ifc.stall_mem});
    end
    ifc.mem_req = 1'b0; ifc.mem_we = 1'b0; ifc.mem_addr = 32'h2000;
    @(negedge clk);
    checks++;
    if (ifc.mem_ack !== 1'b0) begin errors++; $display("FAIL store_pulse: got %b expected 0", ifc.mem_ack); end
  endtask
  task automatic test_simultaneous();
    rkey = 32'h5A5A0000; wait_states = 0;
    ifc.if_addr = 32'h300; ifc.if_req = 1'b1;
    ifc.mem_we = 1'b0; ifc.mem_sel = 4'hF; ifc.mem_addr = 32'h400; ifc.mem_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({ifc.bus_req, ifc.bus_we, ifc.bus_addr} !== {1'b1, 1'b0, 32'h400}) begin
      errors++;
      $display("FAIL sim_first_mem: got %h expected %h", {ifc.bus_req, ifc.bus_we, ifc.bus_addr}, {1'b1, 1'b0, 32'h400});
    end
    @(negedge clk);
    checks++;
    if ({ifc.mem_ack, ifc.if_ack, ifc.mem_rdata} !== {2'b10, 32'h5A5A0400}) begin
      errors++;
      $display("FAIL sim_mem_ack: got %h expected %h", {ifc.mem_ack, ifc.if_ack, ifc.mem_rdata}, {2'b10, 32'h5A5A0400});
    end
    ifc.mem_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({ifc.bus_req, ifc.if_ack, ifc.mem_ack} !== 3'b000) begin
      errors++;
      $display("FAIL sim_gap: got %b expected 000", {ifc.bus_req, ifc.if_ack, ifc.mem_ack});
    end
    @(negedge clk);
    checks++;
    if ({ifc.bus_req, ifc.bus_addr} !== {1'b1, 32'h300}) begin
      errors++;
      $display("FAIL sim_second_if: got %h expected %h", {ifc.bus_req, ifc.bus_addr}, {1'b1, 32'h300});
    end
    @(negedge clk);
    checks++;
    if ({ifc.mem_ack, ifc.if_ack, ifc.if_rdata} !== {2'b01, 32'h5A5A0300}) begin
      errors++;
      $display("FAIL sim_if_ack: got %h expected %h", {ifc.mem_ack, ifc.if_ack, ifc.if_rdata}, {2'b01, 32'h5A5A0300});
    end
    ifc.if_req = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_starvation();
    logic [5:0] exp_mem = 6'b101111;
    rkey = 32'h0; wait_states = 0;
    ifc.if_addr = 32'h500; ifc.if_req = 1'b1;
    ifc.mem_we = 1'b0; ifc.mem_addr = 32'h600; ifc.mem_req = 1'b1;
    for (int g = 0; g < 6; g++) begin
      @(negedge clk);
      checks++;
      if ({ifc.bus_req, ifc.bus_addr} !== {1'b1, exp_mem[g] ? 32'h600 : 32'h500}) begin
        errors++;
        $display("FAIL starve_grant%0d: got %h expected %h", g, {ifc.bus_req, ifc.bus_addr},
                 {1'b1, exp_mem[g] ? 32'h600 : 32'h500});
      end
      @(negedge clk);
      checks++;
      if ({ifc.mem_ack, ifc.if_ack} !== {exp_mem[g], !exp_mem[g]}) begin
        errors++;
        $display("FAIL starve_ack%0d: got %b expected %b", g, {ifc.mem_ack, ifc.if_ack}, {exp_mem[g], !exp_mem[g]});
      end
      if (!exp_mem[g]) ifc.if_req = 1'b0;
      if (g == 5) ifc.mem_req = 1'b0;
      @(negedge clk);
    end
  endtask
  task automatic test_timeout();
    int held = 0;
    hang = 1'b1; rkey = 32'h11110000; wait_states = 0;
    ifc.if_addr = 32'h700; ifc.if_req = 1'b1;
    repeat (16) begin
      @(negedge clk);
      if (ifc.bus_req === 1'b1 && ifc.if_ack === 1'b0) held++;
    end
    checks++;
    if (held != 16) begin errors++; $display("FAIL timeout_busy_cycles: got %0d expected 16", held); end
    @(negedge clk);
    checks++;
    if ({ifc.if_ack, ifc.bus_err, ifc.bus_req, ifc.if_rdata} !== {3'b110, 32'h0}) begin
      errors++;
      $display("FAIL timeout_err: got %h expected %h", {ifc.if_ack, ifc.bus_err, ifc.bus_req, ifc.if_rdata}, {3'b110, 32'h0});
    end
    ifc.if_req = 1'b0; hang = 1'b0;
    @(negedge clk);
    checks++;
    if ({ifc.bus_err, ifc.if_ack} !== 2'b00) begin errors++; $display("FAIL timeout_clear: got %b expected 00", {ifc.bus_err, ifc.if_ack}); end
    ifc.if_addr = 32'h104; ifc.if_req = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ifc.if_ack, ifc.bus_err, ifc.if_rdata} !== {2'b10, 32'h11110104}) begin
      errors++;
      $display("FAIL timeout_recover: got %h expected %h", {ifc.if_ack, ifc.bus_err, ifc.if_rdata}, {2'b10, 32'h11110104});
    end
    ifc.if_req = 1'b0;
    @(negedge clk);
    wait_states = 15;
    ifc.if_addr = 32'h108; ifc.if_req = 1'b1;
    repeat (17) @(negedge clk);
    checks++;
    if ({ifc.if_ack, ifc.bus_err, ifc.if_rdata} !== {2'b10, 32'h11110108}) begin
      errors++;
      $display("FAIL timeout_edge_ack: got %h expected %h", {ifc.if_ack, ifc.bus_err, ifc.if_rdata}, {2'b10, 32'h11110108});
    end
    ifc.if_req = 1'b0; wait_states = 0;
    @(negedge clk);
  endtask
  task automatic test_reset_mid();
    hang = 1'b1; wait_states = 0; rkey = 32'h77770000;
    ifc.mem_we = 1'b0; ifc.mem_sel = 4'hF; ifc.mem_addr = 32'h800; ifc.mem_req = 1'b1;
    @(negedge clk);
    checks++;
    if (ifc.bus_req !== 1'b1) begin errors++; $display("FAIL rstmid_busy: got %b expected 1", ifc.bus_req); end
    rst = 1'b1;
    #1;
    checks++;
    if ({ifc.stall_mem, ifc.stall_if} !== 2'b00) begin errors++; $display("FAIL rstmid_stall: got %b expected 00", {ifc.stall_mem, ifc.stall_if}); end
    @(negedge clk);
    checks++;
    if ({ifc.bus_req, ifc.mem_ack, ifc.bus_err, ifc.mem_rdata} !== 35'h0) begin
      errors++;
      $display("FAIL rstmid_drop: got %h expected 0", {ifc.bus_req, ifc.mem_ack, ifc.bus_err, ifc.mem_rdata});
    end
    rst = 1'b0; ifc.mem_req = 1'b0; hang = 1'b0; force_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({ifc.bus_req, ifc.mem_ack, ifc.if_ack, ifc.mem_rdata} !== 35'h0) begin
        errors++;
        $display("FAIL rstmid_ignore%0d: got %h expected 0", i, {ifc.bus_req, ifc.mem_ack, ifc.if_ack, ifc.mem_rdata});
      end
    end
    force_ack = 1'b0;
    @(negedge clk);
    ifc.mem_addr = 32'h804; ifc.mem_req = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ifc.mem_ack, ifc.bus_err, ifc.mem_rdata} !== {2'b10, 32'h77770804}) begin
      errors++;
      $display("FAIL rstmid_after: got %h expected %h", {ifc.mem_ack, ifc.bus_err, ifc.mem_rdata}, {2'b10, 32'h77770804});
    end
    ifc.mem_req = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    test_reset();
    test_if_fetch();
    test_store();
    test_simultaneous();
    test_starvation();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
